// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch (I) and data (D) paths.
// One transaction is outstanding at a time. D wins by default. A burst
// counter forces a waiting I request to win after MAX_D_BURST D grants.
module mem_port_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  input  logic            if_flush_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [31:0]     if_rdata_o,
  input  logic            d_req_i,
  input  logic [XLEN-1:0] d_adr_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [2:0]      d_size_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_D_BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_D_BURST);
  localparam logic [2:0] SizeWord = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, DROP_I} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   burst_q, burst_d;
  logic              i_req;
  logic              sel_d;
  logic              sel_i;

  // State and burst counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Source selection, memory-side muxing, response routing and next state
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    mem_req_o   = 1'b0;
    mem_adr_o   = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_size_o  = '0;
    i_req       = if_req_i & ~if_flush_i;
    sel_d       = 1'b0;
    sel_i       = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_d = d_req_i & ~(i_req & (burst_q == BurstMax));
        sel_i = ~sel_d & i_req;
        if (sel_d) begin
          mem_req_o   = 1'b1;
          mem_adr_o   = d_adr_i;
          mem_we_o    = d_we_i;
          mem_wdata_o = d_wdata_i;
          mem_size_o  = d_size_i;
          d_gnt_o     = mem_gnt_i;
          if (mem_gnt_i) begin
            state_d = WAIT_D;
            if (!i_req)                 burst_d = '0;
            else if (burst_q != BurstMax) burst_d = burst_q + CntW'(1);
          end
        end else if (sel_i) begin
          mem_req_o  = 1'b1;
          mem_adr_o  = if_adr_i;
          mem_size_o = SizeWord;
          if_gnt_o   = mem_gnt_i;
          if (mem_gnt_i) begin
            state_d = WAIT_I;
            burst_d = '0;
          end
        end
      end
      WAIT_D: begin
        if (mem_rvalid_i) begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = mem_rdata_i;
          state_d    = IDLE;
        end
      end
      WAIT_I: begin
        if (mem_rvalid_i) begin
          if (!if_flush_i) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i[31:0];
          end
          state_d = IDLE;
        end else if (if_flush_i) begin
          state_d = DROP_I;
        end
      end
      DROP_I: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Everything is quiet while reset is held, regardless of inputs
    if (!reset_n) begin
      if_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      d_gnt_o     = 1'b0;
      d_rvalid_o  = 1'b0;
      d_rdata_o   = '0;
      mem_req_o   = 1'b0;
      mem_adr_o   = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      mem_size_o  = '0;
    end
  end

  // Protocol checks
  a_one_gnt: assert property (@(posedge clk) disable iff (!reset_n)
    !(if_gnt_o && d_gnt_o));
  a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == IDLE) |-> !mem_rvalid_i);
  a_req_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (mem_req_o && !mem_gnt_i && !if_flush_i) |=> mem_req_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change on the falling edge and
// outputs are sampled 2 ns later, well away from the rising edge.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset_n;
  logic            if_req_i;
  logic [XLEN-1:0] if_adr_i;
  logic            if_flush_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [31:0]     if_rdata_o;
  logic            d_req_i;
  logic [XLEN-1:0] d_adr_i;
  logic            d_we_i;
  logic [XLEN-1:0] d_wdata_i;
  logic [2:0]      d_size_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [XLEN-1:0] d_rdata_o;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_adr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_D_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
    .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    if_req_i = 0; if_adr_i = '0; if_flush_i = 0;
    d_req_i = 0; d_adr_i = '0; d_we_i = 0; d_wdata_i = '0; d_size_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    if_req_i = 1; d_req_i = 1; d_adr_i = 32'h44; mem_gnt_i = 1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if ({mem_req_o, if_gnt_o, d_gnt_o, mem_adr_o} !== '0) begin
      errors++; $display("FAIL reset_quiet: got req=%0b ig=%0b dg=%0b adr=%h exp all 0",
                         mem_req_o, if_gnt_o, d_gnt_o, mem_adr_o);
    end
    @(negedge clk); idle_inputs(); reset_n = 1; #2;
    checks++; if ({mem_req_o, if_rvalid_o, d_rvalid_o} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got req=%0b irv=%0b drv=%0b exp 0",
                         mem_req_o, if_rvalid_o, d_rvalid_o);
    end
  endtask

  task automatic test_i_only();
    @(negedge clk); if_req_i = 1; if_adr_i = 32'h100; mem_gnt_i = 1; #2;
    checks++; if ({mem_req_o, if_gnt_o, d_gnt_o, mem_we_o} !== 4'b1100 ||
                  mem_adr_o !== 32'h100 || mem_size_o !== 3'b010) begin
      errors++; $display("FAIL i_only_gnt: got req=%0b ig=%0b dg=%0b we=%0b adr=%h sz=%0d exp 1 1 0 0 100 2",
                         mem_req_o, if_gnt_o, d_gnt_o, mem_we_o, mem_adr_o, mem_size_o);
    end
    @(negedge clk); if_req_i = 0; mem_gnt_i = 0; #2;
    checks++; if ({mem_req_o, if_rvalid_o, if_rdata_o} !== '0) begin
      errors++; $display("FAIL i_only_wait: got req=%0b irv=%0b ird=%h exp 0", mem_req_o, if_rvalid_o, if_rdata_o);
    end
    @(negedge clk); mem_rvalid_i = 1; mem_rdata_i = 32'h13; #2;
    checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h13 || d_rvalid_o !== 1'b0 || d_rdata_o !== '0) begin
      errors++; $display("FAIL i_only_rvalid: got irv=%0b ird=%h drv=%0b drd=%h exp 1 13 0 0",
                         if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o);
    end
    @(negedge clk); idle_inputs(); #2;
    checks++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== '0) begin
      errors++; $display("FAIL i_only_after: got irv=%0b ird=%h exp 0 0", if_rvalid_o, if_rdata_o);
    end
  endtask

  task automatic test_d_priority();
    @(negedge clk);
    if_req_i = 1; if_adr_i = 32'h104;
    d_req_i = 1; d_we_i = 1; d_adr_i = 32'h2000; d_wdata_i = 32'hCAFE; d_size_i = 3'b001;
    mem_gnt_i = 1; #2;
    checks++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0 || mem_we_o !== 1'b1 ||
                  mem_wdata_o !== 32'hCAFE || mem_adr_o !== 32'h2000 || mem_size_o !== 3'b001) begin
      errors++; $display("FAIL prio_d_gnt: got dg=%0b ig=%0b we=%0b wd=%h adr=%h sz=%0d exp 1 0 1 cafe 2000 1",
                         d_gnt_o, if_gnt_o, mem_we_o, mem_wdata_o, mem_adr_o, mem_size_o);
    end
    @(negedge clk);
    d_req_i = 0; d_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = '0; #2;
    checks++; if (d_rvalid_o !== 1'b1 || if_gnt_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL prio_d_ack: got drv=%0b ig=%0b req=%0b exp 1 0 0", d_rvalid_o, if_gnt_o, mem_req_o);
    end
    @(negedge clk); mem_rvalid_i = 0; mem_gnt_i = 1; #2;
    checks++; if (if_gnt_o !== 1'b1 || mem_adr_o !== 32'h104 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL prio_i_gnt: got ig=%0b adr=%h we=%0b exp 1 104 0", if_gnt_o, mem_adr_o, mem_we_o);
    end
    @(negedge clk); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h93; #2;
    checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h93) begin
      errors++; $display("FAIL prio_i_rvalid: got irv=%0b ird=%h exp 1 93", if_rvalid_o, if_rdata_o);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_starvation();
    int n_d = 0;
    bit got_i = 0;
    if_req_i = 1; if_adr_i = 32'h108;
    d_req_i = 1; d_we_i = 0; d_adr_i = 32'h3000; d_size_i = 3'b010;
    for (int k = 0; k < 8 && !got_i; k++) begin
      @(negedge clk); mem_gnt_i = 1; mem_rvalid_i = 0; #2;
      if (d_gnt_o === 1'b1) n_d++;
      else if (if_gnt_o === 1'b1) got_i = 1;
      @(negedge clk); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1;
    end
    checks++; if (n_d != 4) begin
      errors++; $display("FAIL starve_d_count: got %0d exp 4", n_d);
    end
    checks++; if (got_i !== 1'b1) begin
      errors++; $display("FAIL starve_i_gnt: got %0b exp 1", got_i);
    end
    @(negedge clk); mem_gnt_i = 1; mem_rvalid_i = 0; #2;
    checks++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      errors++; $display("FAIL starve_cnt_cleared: got dg=%0b ig=%0b exp 1 0", d_gnt_o, if_gnt_o);
    end
    @(negedge clk); idle_inputs(); mem_rvalid_i = 1;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_flush_wait_i();
    @(negedge clk); if_req_i = 1; if_adr_i = 32'h180; mem_gnt_i = 1;
    @(negedge clk); if_req_i = 0; mem_gnt_i = 0; if_flush_i = 1; #2;
    checks++; if (if_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL flush_no_rv_c1: got %0b exp 0", if_rvalid_o);
    end
    @(negedge clk); if_flush_i = 0;
    @(negedge clk); mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD; if_req_i = 1; if_adr_i = 32'h200; #2;
    checks++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== '0 || if_gnt_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got irv=%0b ird=%h ig=%0b req=%0b exp 0 0 0 0",
                         if_rvalid_o, if_rdata_o, if_gnt_o, mem_req_o);
    end
    @(negedge clk); mem_rvalid_i = 0; mem_gnt_i = 1; #2;
    checks++; if (if_gnt_o !== 1'b1 || mem_adr_o !== 32'h200) begin
      errors++; $display("FAIL flush_next_gnt: got ig=%0b adr=%h exp 1 200", if_gnt_o, mem_adr_o);
    end
    @(negedge clk); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h33; #2;
    checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h33) begin
      errors++; $display("FAIL flush_next_rv: got irv=%0b ird=%h exp 1 33", if_rvalid_o, if_rdata_o);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_flush_with_rvalid();
    @(negedge clk); if_req_i = 1; if_adr_i = 32'h300; mem_gnt_i = 1;
    @(negedge clk);
    if_req_i = 0; mem_gnt_i = 0; if_flush_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    d_req_i = 1; d_we_i = 0; d_adr_i = 32'h400; d_size_i = 3'b010; #2;
    checks++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== '0 || d_gnt_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL flushrv_drop: got irv=%0b ird=%h dg=%0b req=%0b exp 0 0 0 0",
                         if_rvalid_o, if_rdata_o, d_gnt_o, mem_req_o);
    end
    @(negedge clk); if_flush_i = 0; mem_rvalid_i = 0; mem_gnt_i = 1; #2;
    checks++; if (d_gnt_o !== 1'b1 || mem_adr_o !== 32'h400 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL flushrv_d_gnt: got dg=%0b adr=%h we=%0b exp 1 400 0", d_gnt_o, mem_adr_o, mem_we_o);
    end
    @(negedge clk); d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77; #2;
    checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h77 || if_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL flushrv_d_rv: got drv=%0b drd=%h irv=%0b exp 1 77 0", d_rvalid_o, d_rdata_o, if_rvalid_o);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid_d();
    @(negedge clk); d_req_i = 1; d_we_i = 0; d_adr_i = 32'h500; d_size_i = 3'b010; mem_gnt_i = 1;
    @(negedge clk); d_req_i = 1; if_req_i = 1; if_adr_i = 32'h600; mem_gnt_i = 1; reset_n = 0; #2;
    checks++; if ({mem_req_o, if_gnt_o, d_gnt_o, d_rvalid_o, if_rvalid_o, mem_adr_o, mem_size_o} !== '0) begin
      errors++; $display("FAIL rst_mid_quiet: got req=%0b ig=%0b dg=%0b drv=%0b irv=%0b adr=%h sz=%0d exp all 0",
                         mem_req_o, if_gnt_o, d_gnt_o, d_rvalid_o, if_rvalid_o, mem_adr_o, mem_size_o);
    end
    @(negedge clk); idle_inputs(); reset_n = 1;
    @(negedge clk); d_req_i = 1; d_we_i = 0; d_adr_i = 32'h700; d_size_i = 3'b010; mem_gnt_i = 1; #2;
    checks++; if (d_gnt_o !== 1'b1 || mem_adr_o !== 32'h700) begin
      errors++; $display("FAIL rst_mid_gnt: got dg=%0b adr=%h exp 1 700", d_gnt_o, mem_adr_o);
    end
    @(negedge clk); d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hABCD; #2;
    checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hABCD) begin
      errors++; $display("FAIL rst_mid_rv: got drv=%0b drd=%h exp 1 abcd", d_rvalid_o, d_rdata_o);
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_d_priority();
    test_starvation();
    test_flush_wait_i();
    test_flush_with_rvalid();
    test_reset_mid_d();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
